led_blink_ctrl: RTL and testbench

Board-level LED controller: generates a slow tick from the 24 MHz HSOSC-derived clock and debounces the four active-low DIP switches. It drives the three board LEDs with switch-selected blink and pattern modes. It is the sequencing layer that replaces direct switch-to-LED gating in the top level, and sits between the oscillator/switch inputs and the `led` pins.

---
 rtl/led_blink_ctrl.sv | 121 ++++++++++++
 tb/tb_led_blink_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_ctrl
// Purpose  : Slow tick generator, DIP-switch sync/debounce, LED blink/pattern.
//            Define LED_DEBOUNCE_EN to build the per-switch debounce counters.
// Revision : 1.0
// ============================================================================
module led_blink_ctrl #(
    parameter int unsigned TICK_CYCLES = 5_000_000,
    parameter int unsigned DB_CYCLES   = 240_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s,
    output logic [2:0] led,
    output logic       tick
);

    localparam logic [31:0] TC_MAX = 32'(TICK_CYCLES - 1);

    logic [3:0]  s_meta;
    logic [3:0]  s_sync;
    logic [3:0]  s_db;
    logic [31:0] tc;
    logic [31:0] tc_next;
    logic        tc_wrap;
    logic [1:0]  tcnt;
    logic [1:0]  pstep;
    logic [1:0]  bmode;
    logic [1:0]  pmode;
    logic [1:0]  pmode_prev;
    logic [2:0]  led_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_meta <= 4'hF;
            s_sync <= 4'hF;
        end else begin
            s_meta <= s;
            s_sync <= s_meta;
        end
    end

`ifdef LED_DEBOUNCE_EN
    localparam logic [19:0] DB_MAX = 20'(DB_CYCLES - 1);

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [19:0] cnt;
        logic        db_bit;

        // Counter only runs while the synchronized bit disagrees with the accepted one.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                db_bit <= 1'b1;
            end else if (s_sync[i] == db_bit) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                cnt    <= '0;
                db_bit <= s_sync[i];
            end else begin
                cnt <= cnt + 20'd1;
            end
        end

        assign s_db[i] = db_bit;
    end
`else
    logic unused_db_cfg;
    assign unused_db_cfg = ^DB_CYCLES;
    assign s_db          = s_sync;
`endif

    assign bmode   = ~s_db[1:0];
    assign pmode   = ~s_db[3:2];
    assign tc_wrap = (tc == TC_MAX);
    assign tc_next = tc_wrap ? 32'd0 : tc + 32'd1;

    always_comb begin
        led_d = 3'b000;
        case (bmode)
            2'b00:   led_d[2] = 1'b0;
            2'b01:   led_d[2] = 1'b1;
            2'b10:   led_d[2] = tcnt[1];
            default: led_d[2] = tcnt[0];
        endcase
        case (pmode)
            2'b00:   led_d[1:0] = 2'b00;
            2'b01:   led_d[1:0] = pstep[0] ? 2'b10 : 2'b01;
            2'b10:   led_d[1:0] = pstep;
            default: led_d[1:0] = (pstep == 2'd3) ? 2'b00 : 2'b11;
        endcase
    end

    // tick is registered from tc_next so it is high exactly while tc == TC_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            tc         <= '0;
            tick       <= 1'b0;
            tcnt       <= '0;
            pstep      <= '0;
            pmode_prev <= '0;
            led        <= '0;
        end else begin
            tc         <= tc_next;
            tick       <= (tc_next == TC_MAX);
            pmode_prev <= pmode;
            led        <= led_d;
            if (tc_wrap) begin
                tcnt <= tcnt + 2'd1;
            end
            if (pmode != pmode_prev) begin
                pstep <= '0;
            end else if (tc_wrap) begin
                pstep <= pstep + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_blink_ctrl.sv
`default_nettype none
// Bench for led_blink_ctrl: cycle model compared every cycle plus literal pins.
module tb_led_blink_ctrl;

    localparam int T  = 4;
    localparam int DB = 3;
`ifdef LED_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
    localparam int GL  = 0;
`else
    localparam int LAT = 2;
    localparam int GL  = 2;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] s     = 4'hF;
    logic [2:0] led;
    logic       tick;

    led_blink_ctrl #(.TICK_CYCLES(T), .DB_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .led   (led),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: switch view two samples back, accepted switches, run lengths,
    // position within the tick period, tick count and pattern step.
    logic [3:0] m_sync1, m_sync2, m_sdb;
    int         m_run[4];
    int         m_tc, m_tcnt, m_pstep;
    logic [1:0] m_pprev;
    logic [2:0] m_led;
    logic       m_tick;
    bit         m_valid = 0;

    function automatic logic [2:0] led_rule(logic [3:0] sdb, int tcnt, int pstep);
        logic [1:0] b, p;
        logic       l2;
        logic [1:0] l10;
        b = ~sdb[1:0];
        p = ~sdb[3:2];
        if (b == 2'd0)      l2 = 1'b0;
        else if (b == 2'd1) l2 = 1'b1;
        else if (b == 2'd2) l2 = ((tcnt / 2) % 2) == 1;
        else                l2 = (tcnt % 2) == 1;
        if (p == 2'd0)      l10 = 2'b00;
        else if (p == 2'd1) l10 = (pstep % 2 == 0) ? 2'b01 : 2'b10;
        else if (p == 2'd2) l10 = 2'(pstep);
        else                l10 = (pstep == 3) ? 2'b00 : 2'b11;
        return {l2, l10};
    endfunction

    task automatic model_step();
        logic [1:0] pmode;
        bit         is_tick;
        if (reset) begin
            m_sync1 = 4'hF; m_sync2 = 4'hF; m_sdb = 4'hF;
            m_run   = '{default: 0};
            m_tc = 0; m_tcnt = 0; m_pstep = 0; m_pprev = 2'b00;
            m_led = 3'b000; m_tick = 1'b0; m_valid = 1;
        end else begin
            is_tick = (m_tc == T - 1);
            m_led   = led_rule(m_sdb, m_tcnt, m_pstep);
            pmode   = ~m_sdb[3:2];
            if (pmode != m_pprev) m_pstep = 0;
            else if (is_tick)     m_pstep = (m_pstep + 1) % 4;
            m_pprev = pmode;
            if (is_tick) m_tcnt = (m_tcnt + 1) % 4;
            m_tc   = (m_tc + 1) % T;
            m_tick = (m_tc == T - 1);
`ifdef LED_DEBOUNCE_EN
            for (int i = 0; i < 4; i++) begin
                if (m_sync2[i] != m_sdb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_sdb[i] = m_sync2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = s;
`else
            m_sync2 = m_sync1;
            m_sync1 = s;
            m_sdb   = m_sync2;
`endif
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (m_valid) begin
            check("led", {29'd0, led}, {29'd0, m_led});
            check("tick", {31'd0, tick}, {31'd0, m_tick});
            check("s_db", {28'd0, dut.s_db}, {28'd0, m_sdb});
        end
    endtask

    task automatic set_sw(logic [3:0] v);
        s = v;
        repeat (LAT + 4) cyc();
    endtask

    task automatic window16(output int tog2, output int n3, output int n0, output int n1);
        logic p;
        tog2 = 0; n3 = 0; n0 = 0; n1 = 0;
        p = led[2];
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (led[2] != p) tog2++;
            p = led[2];
            if (led[1:0] == 2'b11) n3++;
            if (led[1:0] == 2'b00) n0++;
            if (led[1:0] == 2'b01) n1++;
        end
    endtask

    initial begin
        logic [11:0] tpat;
        int tog2, n3, n0, n1, n, x, exp_tcnt;
        bit found;

        reset = 1'b1; s = 4'hF;
        repeat (3) cyc();
        check("rst_led", {29'd0, led}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        reset = 1'b0;
        tpat = '0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            tpat[i] = tick;
        end
        // Tick seen at the 3rd, 7th and 11th edge after reset release.
        check("tick_pattern", {20'd0, tpat}, 32'h444);

        set_sw(4'b1100);
        window16(tog2, n3, n0, n1);
        check("fast_toggles", tog2, 4);
        check("fast_pat_off", n0, 16);

        set_sw(4'b1101);
        window16(tog2, n3, n0, n1);
        check("slow_toggles", tog2, 2);

        set_sw(4'b0111);
        window16(tog2, n3, n0, n1);
        check("count_n11", n3, 4);
        check("count_n00", n0, 4);
        check("count_led2_off", tog2, 0);

        set_sw(4'b1011);
        window16(tog2, n3, n0, n1);
        check("chase_n01", n1, 8);
        check("chase_n00", n0, 0);

        set_sw(4'b0011);
        window16(tog2, n3, n0, n1);
        check("burst_n11", n3, 12);
        check("burst_n00", n0, 4);

        set_sw(4'b1111);
        s = 4'b1110;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) s = 4'hF;
            cyc();
            if (dut.s_db[0] == 1'b0) n++;
        end
        check("glitch_cycles", n, GL);

        s = 4'b1110;
        n = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            n++;
            if (dut.s_db[0] == 1'b0) found = 1;
        end
        check("hold_latency", n, LAT);
        repeat (5) cyc();
        set_sw(4'b1111);

        // Align so the new switch value is accepted on a tick cycle.
        x = (((T - 1 - LAT) % T) + T) % T;
        for (int i = 0; i < 2 * T && m_tc != x; i++) cyc();
        s = 4'b0111;
        repeat (LAT) cyc();
        check("coincide_tick", {31'd0, tick}, 32'd1);
        check("coincide_sdb", {28'd0, dut.s_db}, 32'h7);
        exp_tcnt = (m_tcnt + 1) % 4;
        cyc();
        check("coincide_pstep", {30'd0, dut.pstep}, 32'd0);
        check("coincide_tcnt", {30'd0, dut.tcnt}, exp_tcnt);

        set_sw(4'b0011);
        for (int i = 0; i < 2 * T && m_tc != 2; i++) cyc();
        reset = 1'b1;
        cyc();
        check("mid_rst_tc", dut.tc, 32'd0);
        check("mid_rst_tcnt", {30'd0, dut.tcnt}, 32'd0);
        check("mid_rst_pstep", {30'd0, dut.pstep}, 32'd0);
        check("mid_rst_led", {29'd0, led}, 32'd0);
        check("mid_rst_tick", {31'd0, tick}, 32'd0);
        reset = 1'b0;
        n = 0; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            n++;
            if (tick) found = 1;
        end
        check("first_tick_after_reset", n, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
